// File: rtl/uart_resp_tx.sv
// Response transmitter: queues response bytes in a small FIFO and sends each
// as an 8N1 UART frame on TX, with status and overflow reporting.
module uart_resp_tx #(
    parameter int unsigned BAUD_DIV   = 2604,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_resp,
    input  logic [7:0] resp,
    output logic       TX,
    output logic       tx_busy,
    output logic       resp_sent,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned BAUD_W     = 12;
    localparam int unsigned BIT_W      = 4;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XMIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [9:0]         shift_q, shift_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               tx_q;
    logic               busy_q;
    logic               done_q;
    logic               sent_q;
    logic               full_q;
    logic               ovf_q;

    logic               push_c;
    logic               pop_c;
    logic               drop_c;
    logic               done_c;

    // Next-state: FIFO bookkeeping plus the IDLE/XMIT frame sequencer
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        pop_c    = 1'b0;
        done_c   = 1'b0;
        push_c   = send_resp && (count_q < CNT_W'(FIFO_DEPTH));
        drop_c   = send_resp && (count_q == CNT_W'(FIFO_DEPTH));

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    shift_d = {1'b1, mem_q[rd_ptr_q], 1'b0};
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_XMIT;
                end
            end
            ST_XMIT: begin
                if (baud_q == BAUD_W'(BAUD_DIV - 1)) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[9:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Depth is a power of two, so pointers wrap by natural overflow
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            // TX trails the shift register by one flop; resp_sent follows suit
            tx_q     <= (state_q == ST_XMIT) ? shift_q[0] : 1'b1;
            done_q   <= done_c;
            sent_q   <= done_q;
            busy_q   <= (state_d == ST_XMIT) || (count_d != '0);
            full_q   <= (count_d == CNT_W'(FIFO_DEPTH));
            ovf_q    <= ovf_q || drop_c;
        end
    end

    // Byte storage, not reset: only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem_q[wr_ptr_q] <= resp;
        end
    end

    assign TX        = tx_q;
    assign tx_busy   = busy_q;
    assign resp_sent = sent_q;
    assign fifo_full = full_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_resp_tx.sv
// Bench for uart_resp_tx: queue-level reference model feeding a scoreboard,
// with an independent TX-line decoder as the monitor.
module tb_uart_resp_tx;

    localparam int B   = 16;
    localparam int D   = 4;
    localparam int BD0 = 2604;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_resp;
    logic [7:0] resp;
    logic       TX, tx_busy, resp_sent, fifo_full, overflow;
    logic       send2;
    logic [7:0] resp2;
    logic       TX2, tx_busy2, resp_sent2, fifo_full2, overflow2;

    uart_resp_tx #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .send_resp(send_resp), .resp(resp),
        .TX(TX), .tx_busy(tx_busy), .resp_sent(resp_sent),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    uart_resp_tx dut2 (
        .clk(clk), .rst(rst), .send_resp(send2), .resp(resp2),
        .TX(TX2), .tx_busy(tx_busy2), .resp_sent(resp_sent2),
        .fifo_full(fifo_full2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int         m_next_pop = 0;
    bit         m_ovf = 1'b0;
    bit         chk_en = 1'b0;
    bit         mon_en = 1'b0;
    int         starts[$];
    int         mon_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one edge; the model sees the inputs the DUT sampled on that edge
    task automatic tick();
        int pre;
        bit pop;
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            sb.delete();
            m_next_pop = 0;
            m_ovf = 1'b0;
        end else begin
            pre = mq.size();
            pop = (cyc >= m_next_pop) && (pre > 0);
            if (pop) begin
                sb.push_back(mq.pop_front());
                m_next_pop = cyc + 10 * B + 1;
            end
            if (send_resp && pre < D) mq.push_back(resp);
            if (send_resp && pre == D) m_ovf = 1'b1;
        end
        #2;
        if (chk_en) begin
            check("fifo_full", fifo_full, mq.size() == D);
            check("overflow", overflow, m_ovf);
            check("tx_busy", tx_busy, (mq.size() != 0) || (cyc < m_next_pop - 1));
        end
    endtask

    // Monitor: decode frames from TX at mid-bit and pop expected bytes
    initial begin
        int         pos;
        int         s;
        bit         in_f;
        logic [9:0] bits;
        logic [7:0] exp_b;
        in_f = 1'b0;
        s = 0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                in_f = 1'b0;
            end else begin
                pos = cyc - s;
                if (!(in_f && pos == 10 * B)) check("resp_sent_stray", resp_sent, 1'b0);
                if (!in_f) begin
                    if (TX == 1'b0) begin
                        in_f = 1'b1;
                        s = cyc;
                        starts.push_back(cyc);
                        bits = '0;
                    end
                end else begin
                    if ((pos % B) == B / 2 && (pos / B) < 10) bits[pos / B] = TX;
                    if (pos == 9 * B + B / 2) begin
                        check("start_bit", bits[0], 1'b0);
                        check("stop_bit", bits[9], 1'b1);
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL frame_unexpected: got %0h expected none (cycle %0d)", bits[8:1], cyc);
                        end else begin
                            exp_b = sb.pop_front();
                            check("frame_byte", bits[8:1], exp_b);
                        end
                    end
                    if (pos == 10 * B) begin
                        check("resp_sent_pulse", resp_sent, 1'b1);
                        check("idle_gap_tx", TX, 1'b1);
                        in_f = 1'b0;
                        mon_frames++;
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] a5;
        int         s0, g, f0, t0, last, nt, tsent, burst_len;
        bit         saw_full;
        logic       prev, e;
        rst = 1'b1;
        send_resp = 1'b0;
        resp = '0;
        send2 = 1'b0;
        resp2 = '0;
        a5 = 8'hA5;

        // Reset state
        tick();
        tick();
        check("rst_tx", TX, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_sent", resp_sent, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_tx2", TX2, 1'b1);
        chk_en = 1'b1;
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single byte 0xA5: exact waveform and resp_sent timing
        send_resp = 1'b1;
        resp = a5;
        tick();
        send_resp = 1'b0;
        for (int j = 1; j <= 170; j++) begin
            tick();
            if (j < 2 || j > 161) e = 1'b1;
            else if ((j - 2) / B == 0) e = 1'b0;
            else if ((j - 2) / B == 9) e = 1'b1;
            else e = a5[(j - 2) / B - 1];
            check("a5_tx", TX, e);
            check("a5_resp_sent", resp_sent, j == 162);
        end
        check("a5_busy_after", tx_busy, 1'b0);

        // Burst of four on consecutive clocks
        s0 = starts.size();
        saw_full = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_resp = 1'b1;
            resp = 8'(i);
            tick();
            saw_full |= fifo_full;
        end
        send_resp = 1'b0;
        repeat (4 * 161 + 20) begin
            tick();
            saw_full |= fifo_full;
        end
        check("burst_never_full", saw_full, 1'b0);
        check("burst_frames", starts.size() - s0, 4);
        if (starts.size() - s0 >= 4)
            for (int k = 1; k < 4; k++)
                check("burst_spacing", starts[s0 + k] - starts[s0 + k - 1], 161);

        // Overflow with a frame in flight
        send_resp = 1'b1;
        resp = 8'h11;
        tick();
        send_resp = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            send_resp = 1'b1;
            resp = 8'h21 + 8'(i);
            tick();
        end
        send_resp = 1'b0;
        check("ovf_full", fifo_full, 1'b1);
        check("ovf_set", overflow, 1'b1);

        // Full FIFO, send on the very edge that pops
        g = 0;
        while (cyc + 1 != m_next_pop && g < 400) begin
            tick();
            g++;
        end
        check("pop_edge_found", g < 400, 1'b1);
        send_resp = 1'b1;
        resp = 8'h77;
        tick();
        send_resp = 1'b0;
        check("simul_ovf", overflow, 1'b1);
        check("simul_count3", fifo_full, 1'b0);
        repeat (900) tick();
        check("ovf_sticky", overflow, 1'b1);

        // Reset mid-frame during data bit 3 of 0xFF
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        send_resp = 1'b1;
        resp = 8'hFF;
        tick();
        send_resp = 1'b0;
        repeat (74) tick();
        f0 = mon_frames;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_tx", TX, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        repeat (200) tick();
        check("abort_no_frame", mon_frames - f0, 0);
        send_resp = 1'b1;
        resp = 8'h3C;
        tick();
        send_resp = 1'b0;
        repeat (170) tick();
        check("after_abort_frame", mon_frames - f0, 1);

        // Randomized traffic with occasional bursts
        burst_len = 0;
        repeat (3000) begin
            if (burst_len == 0 && $urandom_range(0, 199) == 0) burst_len = $urandom_range(3, 7);
            send_resp = (burst_len > 0) || ($urandom_range(0, 11) == 0);
            if (burst_len > 0) burst_len--;
            resp = 8'($urandom);
            tick();
        end
        send_resp = 1'b0;
        repeat (1200) tick();
        check("sb_drained", sb.size(), 0);
        check("fifo_drained", mq.size(), 0);

        // Default parameters: 0x55 bit period and frame length
        send2 = 1'b1;
        resp2 = 8'h55;
        tick();
        send2 = 1'b0;
        g = 0;
        while (TX2 !== 1'b0 && g < 10) begin
            tick();
            g++;
        end
        check("dflt_start_seen", TX2, 1'b0);
        t0 = cyc;
        last = t0;
        prev = 1'b0;
        nt = 0;
        tsent = -1;
        for (int i = 0; i < 26100 && tsent < 0; i++) begin
            tick();
            if (TX2 !== prev) begin
                check("dflt_bit_period", cyc - last, BD0);
                last = cyc;
                prev = TX2;
                nt++;
            end
            if (resp_sent2) tsent = cyc;
        end
        check("dflt_transitions", nt, 9);
        check("dflt_frame_len", tsent - t0, 10 * BD0);
        tick();
        check("dflt_busy_after", tx_busy2, 1'b0);
        check("dflt_full", fifo_full2, 1'b0);
        check("dflt_ovf", overflow2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_resp_tx.md
UART_RESP_TX -- requirements
Module: uart_resp_tx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per UART bit (50 MHz / 19200 baud); legal range 4..4095.
REQ-002 Parameter FIFO_DEPTH, default 4, number of queued response bytes; power of two, 2..16.
REQ-003 clk  input  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 send_resp  input  1  one-clock pulse; enqueue resp.
REQ-006 resp  input  8  response byte, sampled only when send_resp=1.
REQ-007 TX  output  1  UART serial line to BLE module, idle high.
REQ-008 tx_busy  output  1  high while a frame is on TX or the FIFO is non-empty.
REQ-009 resp_sent  output  1  one-clock pulse at completion of each frame.
REQ-010 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 overflow  output  1  sticky flag: a send_resp was dropped.

Function
REQ-012 The frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1; each bit held exactly BAUD_DIV clocks; frame length 10*BAUD_DIV clocks.
REQ-013 FIFO push SHALL occur on an edge where send_resp=1 and the pre-edge count < FIFO_DEPTH.
REQ-014 When send_resp=1 with the pre-edge count = FIFO_DEPTH, the byte SHALL be dropped and overflow set, even if a pop occurs on the same edge.
REQ-015 overflow SHALL clear only on rst.
REQ-016 The FSM SHALL have states IDLE and XMIT.
REQ-017 IDLE with FIFO non-empty: pop the head byte, load the shift register {1,data,0}, clear the baud and bit counters, and enter XMIT on the same edge.
REQ-018 XMIT: the baud counter counts 0..BAUD_DIV-1; on terminal count the register shifts right (filling with 1) and the bit counter increments.
REQ-019 When the bit counter reaches 10 at terminal count, the FSM SHALL return to IDLE and pulse resp_sent for that one clock.
REQ-020 TX SHALL be the registered LSB of the shift register in XMIT and 1 in IDLE; it SHALL be glitch-free (driven from a flop).
REQ-021 Latency: with IDLE and an empty FIFO, send_resp at edge N SHALL give a push at N, a pop/load at N+1, and TX=0 from N+2.
REQ-022 Back-to-back frames SHALL be separated by exactly 1 clock of idle-high between the end of the stop bit and the next start bit.
REQ-023 A push and a pop on the same edge SHALL leave the count unchanged, and both SHALL take effect.
REQ-024 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count width is clog2(FIFO_DEPTH)+1.
REQ-025 tx_busy SHALL equal (state==XMIT) | (count!=0), registered-consistent with the state on each clock.
REQ-026 fifo_full SHALL equal (count==FIFO_DEPTH).

Reset
REQ-027 On a rst=1 edge: state=IDLE, TX=1, FIFO emptied (pointers and count 0), counters 0, resp_sent=0, tx_busy=0, fifo_full=0, overflow=0.
REQ-028 A rst asserted mid-frame SHALL abort the frame; TX=1 from the following clock, and no resp_sent pulse occurs.
REQ-029 send_resp coincident with rst=1 SHALL be ignored.

Verification (BAUD_DIV=16, FIFO_DEPTH=4 unless noted)
REQ-030 Single byte: send_resp with resp=0xA5 at edge N -> TX=0 at N+2..N+17, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, stop=1; resp_sent pulses at N+162; tx_busy=0 after.
REQ-031 Burst: send 0x01,0x02,0x03,0x04 on 4 consecutive clocks -> fifo_full never asserts (first byte popped at N+1); four frames decode in order with exactly one idle clock between frames; four resp_sent pulses.
REQ-032 Overflow: with a frame in flight, push 5 bytes back-to-back -> the first 4 are queued, fifo_full=1, the 5th is dropped, overflow=1 and stays 1 until rst; the transmitted sequence excludes the 5th byte.
REQ-033 Full plus simultaneous pop: FIFO full, and send_resp on the exact edge the FSM pops -> the byte is dropped, overflow=1, count=3 afterward.
REQ-034 Reset mid-frame: rst during data bit 3 of 0xFF -> TX=1 the next clock, tx_busy=0, no resp_sent; a subsequent send 0x3C transmits correctly.
REQ-035 Default parameters: one byte 0x55 -> bit period measured at 2604 clocks and frame length 26040 clocks.
